// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit.
// Holds the funct3 operation encodings, the controller state encoding,
// the iteration counter width and small helpers that classify an
// operation (divide vs multiply, which operands are signed).
package muldiv_unit_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CNT_W    = 5;

  typedef enum logic [2:0] {
    F3_MUL    = 3'b000,
    F3_MULH   = 3'b001,
    F3_MULHSU = 3'b010,
    F3_MULHU  = 3'b011,
    F3_DIV    = 3'b100,
    F3_DIVU   = 3'b101,
    F3_REM    = 3'b110,
    F3_REMU   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // Left operand is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic left_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Right operand is treated as signed for MULH, DIV and REM.
  function automatic logic right_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// Single radix-2 iteration of the multiply/divide datapath (combinational).
// One shared adder/subtractor serves both modes.
// Ports:
//   is_div    - 1: restoring divide step, 0: shift-add multiply step
//   acc       - partial product high half / partial remainder
//   shreg     - multiplier bits (LSB first) / dividend bits shifting into quotient
//   opb       - multiplicand magnitude / divisor magnitude
//   acc_nxt   - next acc value
//   shreg_nxt - next shreg value
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] shreg,
  input  logic [XLEN-1:0] opb,
  output logic [XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0] shreg_nxt
);

  logic [XLEN:0]   add_a;
  logic [XLEN:0]   add_b;
  logic [XLEN+1:0] sum;

  always_comb begin
    add_a     = '0;
    add_b     = '0;
    acc_nxt   = acc;
    shreg_nxt = shreg;

    if (is_div) begin
      // Trial subtract: {rem, next dividend bit} - divisor, done as a + ~b + 1.
      add_a = {acc, shreg[XLEN-1]};
      add_b = ~{1'b0, opb};
    end else begin
      add_a = {1'b0, acc};
      add_b = shreg[0] ? {1'b0, opb} : '0;
    end

    sum = {1'b0, add_a} + {1'b0, add_b} + {{(XLEN+1){1'b0}}, is_div};

    if (is_div) begin
      // Carry out means no borrow: the divisor fits, keep the difference.
      acc_nxt   = sum[XLEN+1] ? sum[XLEN-1:0] : add_a[XLEN-1:0];
      shreg_nxt = {shreg[XLEN-2:0], sum[XLEN+1]};
    end else begin
      // Shift the 33-bit sum right into the {acc, shreg} product pair.
      acc_nxt   = sum[XLEN:1];
      shreg_nxt = {sum[0], shreg[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RV32M iterative multiply/divide unit, 32 radix-2 steps per operation.
// Fixed latency: start accepted at edge E0, done pulses after edge E33.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - operation request (accepted in IDLE or FIN)
//   funct3 - RV32M operation select
//   oprl   - left operand (multiplicand / dividend)
//   oprr   - right operand (multiplier / divisor)
//   flush  - synchronous abort, overrides start
//   busy   - high while iterating
//   done   - one-cycle pulse, result valid
//   result - last completed result
//
// state   | meaning
// --------+------------------------------------------------------
// IDLE    | waiting for start
// CALC    | 32 iteration cycles, one step each
// FIN     | sign fix-up and special cases, result written on exit
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] oprl,
  input  logic [XLEN-1:0] oprr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_e            state;
  state_e            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_q;
  logic              neg_l;
  logic              neg_r;
  logic              div_zero;
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   shreg;
  logic [XLEN-1:0]   opb;
  logic [XLEN-1:0]   result_q;
  logic              done_q;

  logic              accept;
  logic              sgn_l;
  logic              sgn_r;
  logic [XLEN-1:0]   mag_l;
  logic [XLEN-1:0]   mag_r;
  logic [XLEN-1:0]   acc_nxt;
  logic [XLEN-1:0]   shreg_nxt;
  logic [XLEN-1:0]   fin_result;
  logic [2*XLEN-1:0] prod_raw;
  logic [2*XLEN-1:0] prod;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div    (is_div_op(f3_q)),
    .acc       (acc),
    .shreg     (shreg),
    .opb       (opb),
    .acc_nxt   (acc_nxt),
    .shreg_nxt (shreg_nxt)
  );

  assign accept = start && !flush && ((state == ST_IDLE) || (state == ST_FIN));

  // The core always works on magnitudes; signs are reapplied in FIN.
  always_comb begin
    sgn_l = left_signed(funct3) && oprl[XLEN-1];
    sgn_r = right_signed(funct3) && oprr[XLEN-1];
    mag_l = sgn_l ? (~oprl + 1'b1) : oprl;
    mag_r = sgn_r ? (~oprr + 1'b1) : oprr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CALC;
      ST_CALC: if (cnt == CNT_LAST) state_nxt = ST_FIN;
      ST_FIN:  state_nxt = start ? ST_CALC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_comb begin
    prod_raw   = {acc, shreg};
    prod       = (neg_l ^ neg_r) ? (~prod_raw + 1'b1) : prod_raw;
    fin_result = '0;
    if (!f3_q[2]) begin
      fin_result = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (!f3_q[1]) begin
      // A zero divisor would otherwise get its all-ones quotient sign-flipped.
      if (div_zero)            fin_result = '1;
      else if (neg_l ^ neg_r)  fin_result = ~shreg + 1'b1;
      else                     fin_result = shreg;
    end else begin
      // With a zero divisor the remainder is |oprl|, so this restores oprl.
      fin_result = neg_l ? (~acc + 1'b1) : acc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      f3_q     <= '0;
      neg_l    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      acc      <= '0;
      shreg    <= '0;
      opb      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == ST_FIN && !flush) begin
        result_q <= fin_result;
        done_q   <= 1'b1;
      end
      if (accept) begin
        f3_q     <= funct3;
        neg_l    <= sgn_l;
        neg_r    <= sgn_r;
        div_zero <= (oprr == '0);
        cnt      <= '0;
        acc      <= '0;
        shreg    <= is_div_op(funct3) ? mag_l : mag_r;
        opb      <= is_div_op(funct3) ? mag_r : mag_l;
      end else if (state == ST_CALC && !flush) begin
        cnt   <= cnt + 1'b1;
        acc   <= acc_nxt;
        shreg <= shreg_nxt;
      end
    end
  end

  assign busy   = (state == ST_CALC);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] oprl;
  logic [31:0] oprr;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks;
  int failures;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .oprl   (oprl),
    .oprr   (oprr),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RV32M semantics with plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa;
    longint     sb;
    longint     ua;
    logic [63:0] p;
    int         ia;
    int         ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ia = a;
    ib = b;
    case (f)
      F3_MUL:    begin p = sa * sb; return p[31:0]; end
      F3_MULH:   begin p = sa * sb; return p[63:32]; end
      F3_MULHSU: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      F3_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      F3_DIVU: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      F3_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
    return ua[31:0];
  endfunction

  // Issue one op from just after an edge; return edges from accept to done.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy_cnt);
    start = 1'b1; funct3 = f; oprl = a; oprr = b;
    @(posedge clk); #1;
    start = 1'b0; oprl = $urandom; oprr = $urandom; funct3 = 3'($urandom_range(7, 0));
    lat = 0; busy_cnt = 0;
    while (!done && lat < 80) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; oprl = '0; oprr = '0;
    #12;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [2:0]  tf [12] = '{F3_MUL, F3_MULH, F3_MULHU, F3_MULHSU, F3_DIV, F3_REM,
                             F3_DIV, F3_REM, F3_DIVU, F3_REMU, F3_DIV, F3_REM};
    logic [31:0] ta [12] = '{32'h7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'h8000_0000, 32'h8000_0000, 32'h5, 32'h5, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    logic [31:0] tb_ [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2, 32'h2,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] te [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                             32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    logic [31:0] res;
    int lat, bc;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      do_op(tf[i], ta[i], tb_[i], res, lat, bc);
      checks++; if (res !== te[i]) begin failures++; $display("FAIL directed_%0d result got=%h exp=%h", i, res, te[i]); end
      checks++; if (lat != 33) begin failures++; $display("FAIL directed_%0d latency got=%0d exp=33", i, lat); end
      checks++; if (bc != 32) begin failures++; $display("FAIL directed_%0d busy_cycles got=%0d exp=32", i, bc); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL directed_%0d done_width got=%0b exp=0", i, done); end
    end
  endtask

  task automatic test_random;
    logic [31:0] pool [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] a, b, res, exp;
    logic [2:0]  f;
    int lat, bc;
    for (int i = 0; i < 48; i++) begin
      f = 3'($urandom_range(7, 0));
      a = ($urandom_range(3, 0) == 0) ? pool[$urandom_range(4, 0)] : $urandom;
      b = ($urandom_range(3, 0) == 0) ? pool[$urandom_range(4, 0)] : $urandom;
      if ($urandom_range(3, 0) == 0) b = 32'($urandom_range(15, 0));
      exp = model(f, a, b);
      do_op(f, a, b, res, lat, bc);
      checks++; if (res !== exp || lat != 33) begin
        failures++;
        $display("FAIL random_%0d f3=%0d a=%h b=%h got=%h exp=%h lat=%0d", i, f, a, b, res, exp, lat);
      end
    end
  endtask

  task automatic test_flush;
    logic [31:0] prior;
    int ndone;
    prior = result;
    start = 1'b1; funct3 = F3_MUL; oprl = 32'h1234; oprr = 32'h5678;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_pre_busy got=%0b exp=1", busy); end
    flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%0b exp=0", busy); end
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
    checks++; if (ndone != 0) begin failures++; $display("FAIL flush_no_done got=%0d exp=0", ndone); end
    checks++; if (result !== prior) begin failures++; $display("FAIL flush_result got=%h exp=%h", result, prior); end
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_over_start got=%0b exp=0", busy); end
  endtask

  task automatic test_ignore_in_calc;
    logic [31:0] exp;
    int lat, ndone;
    exp = model(F3_DIVU, 32'd1000, 32'd7);
    start = 1'b1; funct3 = F3_DIVU; oprl = 32'd1000; oprr = 32'd7;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; funct3 = F3_MUL; oprl = 32'd3; oprr = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    lat = 5;
    while (!done && lat < 80) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 33) begin failures++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
    checks++; if (result !== exp) begin failures++; $display("FAIL ignore_result got=%h exp=%h", result, exp); end
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) ndone++; end
    checks++; if (ndone != 0) begin failures++; $display("FAIL ignore_no_second got=%0d exp=0", ndone); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a2, b2, exp1, exp2;
    int n;
    a2 = $urandom; b2 = $urandom;
    exp1 = model(F3_MULHU, 32'hDEAD_BEEF, 32'h1357_9BDF);
    exp2 = model(F3_REM, a2, b2);
    start = 1'b1; funct3 = F3_MULHU; oprl = 32'hDEAD_BEEF; oprr = 32'h1357_9BDF;
    @(posedge clk); #1; start = 1'b0;
    repeat (32) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL b2b_fin busy=%0b done=%0b exp=0/0", busy, done);
    end
    start = 1'b1; funct3 = F3_REM; oprl = a2; oprr = b2;
    @(posedge clk); #1; start = 1'b0; oprl = $urandom; oprr = $urandom;
    checks++; if (done !== 1'b1 || result !== exp1) begin
      failures++; $display("FAIL b2b_first done=%0b got=%h exp=%h", done, result, exp1);
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_no_bubble got=%0b exp=1", busy); end
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!done && n < 80);
    checks++; if (n != 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", n); end
    checks++; if (result !== exp2) begin failures++; $display("FAIL b2b_second got=%h exp=%h", result, exp2); end
  endtask

  task automatic test_reset_mid;
    int ndone;
    start = 1'b1; funct3 = F3_MUL; oprl = 32'd11; oprr = 32'd13;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    checks++; if (result === 32'h0) begin failures++; $display("FAIL rstmid_prior got=%h exp=nonzero", result); end
    #2; rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      failures++; $display("FAIL rstmid_async busy=%0b done=%0b result=%h exp=0/0/0", busy, done, result);
    end
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) ndone++; end
    checks++; if (ndone != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_ignore_in_calc();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported and verified.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request; sampled only when accept condition holds (REQ-011).
REQ-005 funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 oprl  input  XLEN  left operand (multiplicand/dividend), from operand switcher.
REQ-007 oprr  input  XLEN  right operand (multiplier/divisor), from operand switcher.
REQ-008 flush  input  1  synchronous abort of operation in flight.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse; result valid.

Function
REQ-011 States IDLE, CALC, FIN; start accepted in IDLE or FIN; ignored in CALC.
REQ-012 On accept: latch funct3, operand magnitudes, sign flags, zero-divisor flag; load 5-bit counter = 0; go CALC.
REQ-013 CALC lasts exactly 32 cycles, one radix-2 step per cycle (shift-add multiply, restoring divide on magnitudes); counter == 31 -> FIN.
REQ-014 FIN lasts one cycle: sign correction, special-case override, result register written; done = 1 during the cycle after the FIN edge... latency fixed: start sampled at edge E0 -> done high after edge E33, result stable from same edge.
REQ-015 result output XLEN, holds last value until next done; busy = 1 in CALC only; done = 1 only in the cycle following FIN.
REQ-016 Multiply: MUL low 32 of product; MULH signed x signed high 32; MULHSU signed oprl x unsigned oprr high 32; MULHU unsigned high 32; internal product 64 bits.
REQ-017 Divide: quotient truncates toward zero; remainder takes sign of dividend.
REQ-018 Divisor zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result = oprl unchanged.
REQ-019 Overflow DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; no exception flag.
REQ-020 start in FIN (same cycle as done pulse) begins next op back-to-back; no bubble.
REQ-021 flush in any state -> IDLE next edge; busy low; no done; result unchanged; flush overrides simultaneous start.
REQ-022 Operand inputs need not be held stable after the accepting edge.

Reset
REQ-023 rst_n low -> state IDLE, counter 0, busy 0, done 0, result 0, all datapath registers 0, immediately and independent of clk.
REQ-024 Reset mid-CALC discards the operation; no done pulse after release.
REQ-025 First accept possible on the first rising edge with rst_n high.

Structure
REQ-026 funct3 encodings and state encodings shall be constants in the shared definitions package alongside the existing ALU/operand-type definitions.
REQ-027 One sub-module is natural: muldiv_step, combinational single-iteration add/subtract-shift datapath; FSM and registers stay in muldiv_unit.
REQ-028 No multiplier primitives or '*', '/', '%' operators; one 33-bit adder/subtractor shared by both paths.

Verification
REQ-029 MUL 7 x 0xFFFFFFFD, start at E0 -> result 0xFFFFFFEB, done only after E33, busy high 32 cycles.
REQ-030 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-032 DIVU 5 / 0 -> 0xFFFFFFFF; REMU 5 % 0 -> 5; DIV 0xFFFFFFFB / 0 -> 0xFFFFFFFF; REM -> 0xFFFFFFFB.
REQ-033 flush at 10th CALC cycle -> busy 0 next cycle, no done, result keeps prior value; start during CALC ignored; start in FIN -> second done exactly 33 cycles later.
REQ-034 rst_n asserted mid-CALC -> busy, done, result 0 without clock edge; no done after release.
